// File: rtl/vchess_core.sv
// vchess_core: chess board holder and material evaluator.
//
// Holds one 8x8 board of 4-bit piece codes. The code for square (r, c) sits at
// bits [(r*8+c)*4 +: 4]. Row 0 is the white back rank. Code bit 3 is the
// colour (0 white, 1 black). Bits 2:0 are the piece type.
// After reset or an accepted load, the board is scanned one square per clock.
// The block then publishes the material totals, the signed evaluation and the
// king squares.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   board_in          board to latch when board_load is accepted (in IDLE only)
//   board_load        load request; ignored while scanning or in DONE
//   board_out         currently stored board
//   busy              high while a scan is in progress
//   eval_valid        one-cycle pulse when the result outputs update
//   white_material    unsigned white material total
//   black_material    unsigned black material total
//   eval              17-bit two's complement, white minus black
//   white_king_sq     square index of the white king (highest index wins)
//   black_king_sq     square index of the black king (highest index wins)
//   white_king_found  at least one white king was seen
//   black_king_found  at least one black king was seen
module vchess_core #(
  parameter int PIECE_BITS  = 4,
  parameter int BOARD_WIDTH = PIECE_BITS * 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_WIDTH-1:0] board_in,
  input  logic                   board_load,
  output logic [BOARD_WIDTH-1:0] board_out,
  output logic                   busy,
  output logic                   eval_valid,
  output logic [15:0]            white_material,
  output logic [15:0]            black_material,
  output logic [16:0]            eval,
  output logic [5:0]             white_king_sq,
  output logic [5:0]             black_king_sq,
  output logic                   white_king_found,
  output logic                   black_king_found
);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DONE,
    ST_IDLE
  } state_e;

  localparam logic [2:0] TYPE_KING = 3'd6;

  // Material value of a piece type. Type 7 is treated as empty.
  function automatic logic [15:0] piece_value(input logic [2:0] ptype);
    case (ptype)
      3'd1:    piece_value = 16'd100;
      3'd2:    piece_value = 16'd300;
      3'd3:    piece_value = 16'd300;
      3'd4:    piece_value = 16'd500;
      3'd5:    piece_value = 16'd900;
      default: piece_value = 16'd0;
    endcase
  endfunction

  // Back-rank piece type by column: R N B Q K B N R.
  function automatic logic [2:0] back_rank_type(input int col);
    case (col)
      0, 7:    back_rank_type = 3'd4;
      1, 6:    back_rank_type = 3'd2;
      2, 5:    back_rank_type = 3'd3;
      3:       back_rank_type = 3'd5;
      default: back_rank_type = TYPE_KING;
    endcase
  endfunction

  function automatic logic [BOARD_WIDTH-1:0] start_board();
    logic [BOARD_WIDTH-1:0] b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[c*PIECE_BITS      +: PIECE_BITS] = {1'b0, back_rank_type(c)};
      b[(8+c)*PIECE_BITS  +: PIECE_BITS] = 4'h1;
      b[(48+c)*PIECE_BITS +: PIECE_BITS] = 4'h9;
      b[(56+c)*PIECE_BITS +: PIECE_BITS] = {1'b1, back_rank_type(c)};
    end
    return b;
  endfunction

  state_e                 state_q;
  logic [BOARD_WIDTH-1:0] board_q;
  logic [5:0]             idx_q;
  logic [15:0]            white_acc_q, black_acc_q;
  logic [5:0]             white_ksq_acc_q, black_ksq_acc_q;
  logic                   white_kf_acc_q, black_kf_acc_q;

  logic                   busy_q, eval_valid_q;
  logic [15:0]            white_mat_q, black_mat_q;
  logic [16:0]            eval_q;
  logic [5:0]             white_ksq_q, black_ksq_q;
  logic                   white_kf_q, black_kf_q;

  // Decode of the square currently under the scan pointer.
  logic [PIECE_BITS-1:0]  sq_code;
  logic [15:0]            sq_value;
  logic                   sq_king;
  logic [15:0]            white_acc_d, black_acc_d;

  assign sq_code  = board_q[int'(idx_q)*PIECE_BITS +: PIECE_BITS];
  assign sq_value = piece_value(sq_code[2:0]);
  assign sq_king  = (sq_code[2:0] == TYPE_KING);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    white_acc_d = white_acc_q;
    black_acc_d = black_acc_q;
    if (sq_code[3]) black_acc_d = black_acc_q + sq_value;
    else            white_acc_d = white_acc_q + sq_value;
  end

  // NOTE: the board is 256 ordinary flops, not a RAM, so resetting it to the
  // starting position is legal and cheap. All sequential state uses <= so every
  // register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board_q         <= start_board();
      state_q         <= ST_SCAN;
      idx_q           <= '0;
      white_acc_q     <= '0;
      black_acc_q     <= '0;
      white_ksq_acc_q <= '0;
      black_ksq_acc_q <= '0;
      white_kf_acc_q  <= 1'b0;
      black_kf_acc_q  <= 1'b0;
      busy_q          <= 1'b1;
      eval_valid_q    <= 1'b0;
      white_mat_q     <= '0;
      black_mat_q     <= '0;
      eval_q          <= '0;
      white_ksq_q     <= '0;
      black_ksq_q     <= '0;
      white_kf_q      <= 1'b0;
      black_kf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          eval_valid_q <= 1'b0;
          white_acc_q  <= white_acc_d;
          black_acc_q  <= black_acc_d;
          // The scan is ascending, so a later king overwrites an earlier one.
          if (sq_king) begin
            if (sq_code[3]) begin
              black_ksq_acc_q <= idx_q;
              black_kf_acc_q  <= 1'b1;
            end else begin
              white_ksq_acc_q <= idx_q;
              white_kf_acc_q  <= 1'b1;
            end
          end
          idx_q <= idx_q + 6'd1;
          if (idx_q == 6'd63) state_q <= ST_DONE;
        end
        ST_DONE: begin
          white_mat_q  <= white_acc_q;
          black_mat_q  <= black_acc_q;
          eval_q       <= {1'b0, white_acc_q} - {1'b0, black_acc_q};
          white_ksq_q  <= white_ksq_acc_q;
          black_ksq_q  <= black_ksq_acc_q;
          white_kf_q   <= white_kf_acc_q;
          black_kf_q   <= black_kf_acc_q;
          eval_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin  // ST_IDLE
          eval_valid_q <= 1'b0;
          if (board_load) begin
            board_q         <= board_in;
            idx_q           <= '0;
            white_acc_q     <= '0;
            black_acc_q     <= '0;
            white_ksq_acc_q <= '0;
            black_ksq_acc_q <= '0;
            white_kf_acc_q  <= 1'b0;
            black_kf_acc_q  <= 1'b0;
            busy_q          <= 1'b1;
            state_q         <= ST_SCAN;
          end
        end
      endcase
    end
  end

  assign board_out        = board_q;
  assign busy             = busy_q;
  assign eval_valid       = eval_valid_q;
  assign white_material   = white_mat_q;
  assign black_material   = black_mat_q;
  assign eval             = eval_q;
  assign white_king_sq    = white_ksq_q;
  assign black_king_sq    = black_ksq_q;
  assign white_king_found = white_kf_q;
  assign black_king_found = black_kf_q;

endmodule

// File: tb/tb_vchess_core.sv
// Directed testbench for vchess_core. It loads hand-built boards and checks
// the scan latency and the published results against hand-computed values.
module tb_vchess_core;

  logic         clk;
  logic         reset;
  logic [255:0] board_in;
  logic         board_load;
  logic [255:0] board_out;
  logic         busy;
  logic         eval_valid;
  logic [15:0]  white_material, black_material;
  logic [16:0]  eval;
  logic [5:0]   white_king_sq, black_king_sq;
  logic         white_king_found, black_king_found;

  int checks = 0;
  int errors = 0;

  vchess_core dut (
    .clk              (clk),
    .reset            (reset),
    .board_in         (board_in),
    .board_load       (board_load),
    .board_out        (board_out),
    .busy             (busy),
    .eval_valid       (eval_valid),
    .white_material   (white_material),
    .black_material   (black_material),
    .eval             (eval),
    .white_king_sq    (white_king_sq),
    .black_king_sq    (black_king_sq),
    .white_king_found (white_king_found),
    .black_king_found (black_king_found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] code);
    logic [255:0] r;
    r = b;
    r[sq*4 +: 4] = code;
    return r;
  endfunction

  function automatic logic [255:0] start_pos();
    logic [3:0]   row0 [8];
    logic [255:0] b;
    row0 = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b = put(b, c, row0[c]);
      b = put(b, 8 + c, 4'h1);
      b = put(b, 48 + c, 4'h9);
      b = put(b, 56 + c, row0[c] | 4'h8);
    end
    return b;
  endfunction

  // Counts rising edges until eval_valid is seen, sampling 1 time unit after each edge.
  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!eval_valid && n < 200);
  endtask

  // Drives board_in with board_load for exactly one rising edge.
  task automatic load(input logic [255:0] b);
    @(negedge clk);
    board_in   = b;
    board_load = 1'b1;
    @(posedge clk);
    #1;
    board_load = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] w, input logic [15:0] bl,
                               input logic [16:0] e, input logic [5:0] wk, input logic [5:0] bk,
                               input logic wf, input logic bf);
    check({tag, ".valid"}, 256'(eval_valid), 256'(1'b1));
    check({tag, ".busy"},  256'(busy), 256'(1'b0));
    check({tag, ".wmat"},  256'(white_material), 256'(w));
    check({tag, ".bmat"},  256'(black_material), 256'(bl));
    check({tag, ".eval"},  256'(eval), 256'(e));
    check({tag, ".wksq"},  256'(white_king_sq), 256'(wk));
    check({tag, ".bksq"},  256'(black_king_sq), 256'(bk));
    check({tag, ".wkf"},   256'(white_king_found), 256'(wf));
    check({tag, ".bkf"},   256'(black_king_found), 256'(bf));
  endtask

  initial begin
    logic [255:0] b;
    logic [255:0] first_board;
    int n;

    reset      = 1'b0;
    board_load = 1'b0;
    board_in   = '0;

    // Reset state.
    repeat (64) @(posedge clk);
    @(negedge clk);
    check("rst.busy",  256'(busy), 256'(1'b1));
    check("rst.valid", 256'(eval_valid), 256'(1'b0));
    check("rst.wmat",  256'(white_material), 256'(16'd0));
    check("rst.eval",  256'(eval), 256'(17'd0));
    check("rst.kf",    256'({white_king_found, black_king_found}), 256'(2'b00));
    check("rst.board", board_out, start_pos());

    // Starting-position scan after reset release.
    reset = 1'b1;
    wait_result(n);
    check("start.latency", 256'(n), 256'(65));
    expect_result("start", 16'd3900, 16'd3900, 17'd0, 6'd4, 6'd60, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("start.pulse", 256'(eval_valid), 256'(1'b0));
    check("start.idle_busy", 256'(busy), 256'(1'b0));
    check("start.hold", 256'(white_material), 256'(16'd3900));

    // Kings plus a white queen in the centre.
    b = put(put(put(256'd0, 4, 4'h6), 60, 4'hE), 27, 4'h5);
    load(b);
    check("kq.busy", 256'(busy), 256'(1'b1));
    check("kq.board", board_out, b);
    wait_result(n);
    check("kq.latency", 256'(n), 256'(65));
    expect_result("kq", 16'd900, 16'd0, 17'd900, 6'd4, 6'd60, 1'b1, 1'b1);

    // Starting position without the white queen: eval = -900.
    load(put(start_pos(), 3, 4'h0));
    wait_result(n);
    check("noq.latency", 256'(n), 256'(65));
    expect_result("noq", 16'd3000, 16'd3900, 17'h1FC7C, 6'd4, 6'd60, 1'b1, 1'b1);

    // Empty board with black-empty (8) and type-7 codes (7, F).
    b = put(put(put(put(256'd0, 0, 4'h8), 17, 4'h7), 45, 4'hF), 63, 4'h8);
    load(b);
    wait_result(n);
    expect_result("empty", 16'd0, 16'd0, 17'd0, 6'd0, 6'd0, 1'b0, 1'b0);

    // Several kings per colour: the highest index wins. Black rook adds 500.
    b = put(put(put(put(put(256'd0, 5, 4'h6), 40, 4'h6), 2, 4'hE), 63, 4'hE), 10, 4'hC);
    load(b);
    wait_result(n);
    expect_result("multik", 16'd0, 16'd500, 17'h1FE0C, 6'd40, 6'd63, 1'b1, 1'b1);

    // A load during a scan is ignored. The first board has pieces at squares 0 and 63.
    first_board = put(put(256'd0, 0, 4'hD), 63, 4'h1);
    load(first_board);
    repeat (10) @(posedge clk);
    @(negedge clk);
    board_in   = start_pos();
    board_load = 1'b1;
    @(posedge clk);
    #1;
    board_load = 1'b0;
    check("midload.busy", 256'(busy), 256'(1'b1));
    check("midload.board", board_out, first_board);
    wait_result(n);
    check("midload.latency", 256'(n), 256'(54));
    expect_result("midload", 16'd100, 16'd900, 17'h1FCE0, 6'd0, 6'd0, 1'b0, 1'b0);

    // Reset at scan index 30 aborts the scan and restores the start position.
    load(put(256'd0, 20, 4'h5));
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort.busy",  256'(busy), 256'(1'b1));
    check("abort.valid", 256'(eval_valid), 256'(1'b0));
    check("abort.wmat",  256'(white_material), 256'(16'd0));
    check("abort.bmat",  256'(black_material), 256'(16'd0));
    check("abort.kf",    256'({white_king_found, black_king_found}), 256'(2'b00));
    check("abort.board", board_out, start_pos());
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_result(n);
    check("abort.latency", 256'(n), 256'(65));
    expect_result("abort", 16'd3900, 16'd3900, 17'd0, 6'd4, 6'd60, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vchess_core.md
Name: vchess_core

Overview:
- Chess board holder and material evaluator for the vchess engine.
- Stores one 8x8 board of 4-bit piece codes, initialised to the standard starting position on reset.
- Scans the board one square per clock and reports material totals, a signed evaluation, and king locations.
- Sits below the engine top level as the first board-analysis stage. Later move-generation blocks consume board_out.

Parameters:
- PIECE_BITS, 4, width of one square code.
- BOARD_WIDTH, 256, PIECE_BITS*64.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- board_in  in  BOARD_WIDTH  new board contents. Square (row r, col c) is at bits [(r*8+c)*4 +: 4]. Row 0 is the white back rank.
- board_load  in  1  request to latch board_in and start a scan.
- board_out  out  BOARD_WIDTH  currently stored board.
- busy  out  1  high while a scan is in progress.
- eval_valid  out  1  one-cycle pulse when the results below update.
- white_material  out  16  unsigned white material total.
- black_material  out  16  unsigned black material total.
- eval  out  17  signed value, white_material minus black_material.
- white_king_sq  out  6  square index r*8+c of the white king.
- black_king_sq  out  6  square index r*8+c of the black king.
- white_king_found  out  1  at least one white king was found.
- black_king_found  out  1  at least one black king was found.

Behaviour:
- Piece code: bit3 is colour (0 white, 1 black); bits2:0 are the type.
- Types and values:
  - 0 empty.
  - 1 pawn, 100.
  - 2 knight, 300.
  - 3 bishop, 300.
  - 4 rook, 500.
  - 5 queen, 900.
  - 6 king, 0.
- Type 7 and code 8 (black empty) are treated as empty: no material, no king.
- States are SCAN, DONE and IDLE.
- While reset is low:
  - The board is loaded with the starting position. Row 0 is R N B Q K B N R white; row 1 is white pawns; row 6 is black pawns; row 7 mirrors row 0 in black.
  - State = SCAN, index = 0, accumulators = 0.
  - All result outputs and eval_valid = 0; king_found = 0.
  - busy = 1.
- SCAN:
  - Each rising edge examines the square at index, adds its value to the colour's accumulator, and increments index.
  - A king updates that colour's king square accumulator and sets its found flag. With multiple kings, the highest-index one wins.
  - After index 63 is processed (64 edges), the state goes to DONE.
- DONE (one cycle):
  - Registered outputs take the accumulator values; eval_valid = 1; busy = 0.
  - Next state is IDLE.
- IDLE:
  - busy = 0; outputs hold their values.
  - board_load = 1 latches board_in into the board and clears the accumulators and index; next state is SCAN.
- board_load is ignored in SCAN and DONE. The board never changes during a scan.
- Latency: a load accepted at edge N gives eval_valid high in the cycle following edge N+65.
- After reset release, the first eval_valid occurs in the cycle following the 65th edge.
- Arithmetic:
  - Accumulators are 16-bit unsigned; the maximum is 64*900 = 57600, so there is no overflow.
  - eval is computed in 17-bit two's complement.
- Reset asserted mid-scan aborts the scan immediately and restores the starting position.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Hold reset low for 64 cycles, then release. eval_valid pulses once after about 65 edges, with:
  - white_material = 3900, black_material = 3900, eval = 0;
  - white_king_sq = 4, black_king_sq = 60, both found = 1.
- Load a board with only a white king at 4, a black king at 60 and a white queen at 27. After 66 edges:
  - eval = +900, white_material = 900, black_material = 0.
- Load a starting position with the white queen removed. eval = -900 and white_material = 3000.
- Load an all-empty board, including some code 8 and type-7 squares. All materials = 0, eval = 0, both found = 0.
- Pulse board_load during SCAN. It is ignored, and the next result still reflects the first board.
- Assert reset at scan index 30. Outputs clear and busy = 1; after release the starting-position result is reproduced.
